// File: rtl/sdram_ctrl_x16.sv
// rtl/sdram_ctrl_x16.sv - closed-page x16 SDR SDRAM controller behind a 32-bit req/ack/valid port
// Each host word is one burst-of-2 access with auto-precharge; auto-refresh is interleaved.
module sdram_ctrl_x16 #(
  parameter int INIT_WAIT      = 19200,
  parameter int T_RP           = 2,
  parameter int T_RCD          = 2,
  parameter int T_RC           = 7,
  parameter int T_WR           = 2,
  parameter int CAS_LATENCY    = 2,
  parameter int REFRESH_PERIOD = 750
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [22:0] sdram_addr,
  input  logic [31:0] sdram_data,
  input  logic        sdram_we,
  input  logic        sdram_req,
  output logic        sdram_ack,
  output logic        sdram_valid,
  output logic [31:0] sdram_q,
  output logic        init_done,
  output logic        sd_cke,
  output logic        sd_cs_n,
  output logic        sd_ras_n,
  output logic        sd_cas_n,
  output logic        sd_we_n,
  output logic [1:0]  sd_ba,
  output logic [12:0] sd_a,
  output logic [1:0]  sd_dqm,
  input  logic [15:0] sd_dq_i,
  output logic [15:0] sd_dq_o,
  output logic        sd_dq_oe
);
  localparam int CW     = 16;
  localparam int WR_END = T_RCD + 1 + T_WR + T_RP;
  localparam int TURN_A = (T_RC > WR_END) ? T_RC : WR_END;
  localparam int RD_END = T_RCD + CAS_LATENCY + 2;
  localparam int TURN   = (TURN_A > RD_END) ? TURN_A : RD_END;

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] RP_LAST   = CW'(T_RP - 1);
  localparam logic [CW-1:0] RC_LAST   = CW'(T_RC - 1);
  localparam logic [CW-1:0] RCD_LAST  = CW'(T_RCD - 1);
  localparam logic [CW-1:0] WR_BEAT1  = CW'(T_RCD);
  localparam logic [CW-1:0] RD_CAP    = CW'(RD_END - 1);
  localparam logic [CW-1:0] ACC_LAST  = CW'(TURN - 1);
  localparam logic [CW-1:0] REF_LAST  = CW'(REFRESH_PERIOD - 1);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam logic [12:0] MODE_WORD = {3'b000, 1'b0, 2'b00, 3'(CAS_LATENCY), 1'b0, 3'b001};

  typedef enum logic [2:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2,
    S_INIT_MODE, S_IDLE, S_REFRESH, S_ACCESS
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic          cke_q, cke_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [1:0]    ba_q, ba_d, dqm_q, dqm_d;
  logic [12:0]   a_q, a_d;
  logic [15:0]   dq_o_q, dq_o_d, dq_in_q;
  logic          dq_oe_q, dq_oe_d, ack_q, ack_d, valid_q, valid_d, init_done_q, init_done_d;
  logic [31:0]   q_q, q_d, data_q, data_d;
  logic [1:0]    lat_ba_q, lat_ba_d;
  logic [7:0]    lat_col_q, lat_col_d;
  logic          we_q, we_d;
  logic          ref_term, refresh_due, dispatch;

  assign ref_term    = init_done_q && (ref_cnt_q == REF_LAST);
  assign refresh_due = ref_pend_q || ref_term;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    cke_d       = cke_q;
    cmd_d       = CMD_NOP;
    ba_d        = ba_q;
    a_d         = a_q;
    dqm_d       = dqm_q;
    dq_o_d      = 16'h0000;
    dq_oe_d     = 1'b0;
    ack_d       = 1'b0;
    valid_d     = 1'b0;
    q_d         = q_q;
    init_done_d = init_done_q;
    lat_ba_d    = lat_ba_q;
    lat_col_d   = lat_col_q;
    data_d      = data_q;
    we_d        = we_q;
    dispatch    = 1'b0;
    ref_cnt_d   = init_done_q ? (ref_term ? '0 : ref_cnt_q + 1'b1) : '0;

    case (state_q)
      S_INIT_WAIT: begin
        cke_d = 1'b1;
        if (cnt_q == INIT_LAST) begin
          cmd_d   = CMD_PRE;
          a_d     = 13'h0400;
          state_d = S_INIT_PRE;
          cnt_d   = '0;
        end
      end
      S_INIT_PRE: if (cnt_q == RP_LAST) begin
        cmd_d   = CMD_REF;
        state_d = S_INIT_REF1;
        cnt_d   = '0;
      end
      S_INIT_REF1: if (cnt_q == RC_LAST) begin
        cmd_d   = CMD_REF;
        state_d = S_INIT_REF2;
        cnt_d   = '0;
      end
      S_INIT_REF2: if (cnt_q == RC_LAST) begin
        cmd_d   = CMD_MRS;
        ba_d    = 2'b00;
        a_d     = MODE_WORD;
        state_d = S_INIT_MODE;
        cnt_d   = '0;
      end
      S_INIT_MODE: if (cnt_q == CW'(1)) begin
        state_d     = S_IDLE;
        init_done_d = 1'b1;
        dqm_d       = 2'b00;
        cnt_d       = '0;
      end
      S_IDLE:    dispatch = 1'b1;
      S_REFRESH: dispatch = (cnt_q == RC_LAST);
      S_ACCESS: begin
        if (cnt_q == RCD_LAST) begin
          cmd_d = we_q ? CMD_WRITE : CMD_READ;
          ba_d  = lat_ba_q;
          a_d   = {2'b00, 1'b1, 1'b0, lat_col_q, 1'b0};
          if (we_q) begin
            dq_oe_d = 1'b1;
            dq_o_d  = data_q[15:0];
          end
        end
        if (we_q && cnt_q == WR_BEAT1) begin
          dq_oe_d = 1'b1;
          dq_o_d  = data_q[31:16];
        end
        // beat0 already sits in dq_in_q; beat1 is still on the pins this cycle
        if (!we_q && cnt_q == RD_CAP) begin
          q_d     = {sd_dq_i, dq_in_q};
          valid_d = 1'b1;
        end
        dispatch = (cnt_q == ACC_LAST);
      end
      default: begin
        state_d = init_done_q ? S_IDLE : S_INIT_WAIT;
        cnt_d   = '0;
      end
    endcase

    // refresh outranks a host request, including one arriving on the terminal count
    if (dispatch) begin
      cnt_d = '0;
      if (refresh_due) begin
        cmd_d   = CMD_REF;
        state_d = S_REFRESH;
      end else if (sdram_req) begin
        cmd_d     = CMD_ACT;
        ba_d      = sdram_addr[22:21];
        a_d       = sdram_addr[20:8];
        ack_d     = 1'b1;
        lat_ba_d  = sdram_addr[22:21];
        lat_col_d = sdram_addr[7:0];
        data_d    = sdram_data;
        we_d      = sdram_we;
        state_d   = S_ACCESS;
      end else begin
        state_d = S_IDLE;
      end
    end

    ref_pend_d = refresh_due && !(dispatch && refresh_due);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_INIT_WAIT;
      cnt_q       <= '0;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      cke_q       <= 1'b0;
      cmd_q       <= CMD_DESEL;
      ba_q        <= 2'b00;
      a_q         <= 13'h0000;
      dqm_q       <= 2'b11;
      dq_o_q      <= 16'h0000;
      dq_oe_q     <= 1'b0;
      dq_in_q     <= 16'h0000;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      q_q         <= 32'h0;
      init_done_q <= 1'b0;
      lat_ba_q    <= 2'b00;
      lat_col_q   <= 8'h00;
      data_q      <= 32'h0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      cke_q       <= cke_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      a_q         <= a_d;
      dqm_q       <= dqm_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      dq_in_q     <= sd_dq_i;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      q_q         <= q_d;
      init_done_q <= init_done_d;
      lat_ba_q    <= lat_ba_d;
      lat_col_q   <= lat_col_d;
      data_q      <= data_d;
      we_q        <= we_d;
    end
  end

  assign sdram_ack   = ack_q;
  assign sdram_valid = valid_q;
  assign sdram_q     = q_q;
  assign init_done   = init_done_q;
  assign sd_cke      = cke_q;
  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;
  assign sd_ba       = ba_q;
  assign sd_a        = a_q;
  assign sd_dqm      = dqm_q;
  assign sd_dq_o     = dq_o_q;
  assign sd_dq_oe    = dq_oe_q;
endmodule

// File: tb/tb_sdram_ctrl_x16.sv
// tb/tb_sdram_ctrl_x16.sv - directed scoreboard bench for sdram_ctrl_x16 with a small SDRAM model
`timescale 1ns/1ps
module tb_sdram_ctrl_x16;
  localparam int CL     = 2;
  localparam int T_RC   = 7;
  localparam int RD_LAT = 2 + CL + 2;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000, C_DES = 4'b1111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we, sdram_req, sdram_ack, sdram_valid, init_done;
  logic [31:0] sdram_q;
  logic        sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_dq_oe;
  logic [1:0]  sd_ba, sd_dqm;
  logic [12:0] sd_a;
  logic [15:0] sd_dq_i = 16'h0;
  logic [15:0] sd_dq_o;

  sdram_ctrl_x16 #(.INIT_WAIT(16), .CAS_LATENCY(CL)) dut (
    .clk(clk), .reset_n(reset_n), .sdram_addr(sdram_addr), .sdram_data(sdram_data),
    .sdram_we(sdram_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
    .sdram_q(sdram_q), .init_done(init_done), .sd_cke(sd_cke), .sd_cs_n(sd_cs_n),
    .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n), .sd_we_n(sd_we_n), .sd_ba(sd_ba), .sd_a(sd_a),
    .sd_dqm(sd_dqm), .sd_dq_i(sd_dq_i), .sd_dq_o(sd_dq_o), .sd_dq_oe(sd_dq_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0, n_fail = 0, n_valid = 0, n_reads = 0;

  typedef struct { logic [31:0] data; int ack_cyc; } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cmd_now();
    return {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};
  endfunction

  // SDRAM model: remembers open rows, stores write bursts, returns read bursts CL cycles after READ
  logic [15:0] mem [logic [23:0]];
  logic [12:0] open_row [4];
  logic [23:0] rd_key, wr_key;
  int          rd_at = -100;
  bit          wr_pend = 1'b0;
  int          last_ref = -1;

  function automatic logic [15:0] mem_rd(input logic [23:0] k);
    return mem.exists(k) ? mem[k] : 16'h0000;
  endfunction

  always @(negedge clk) begin
    logic [3:0] c;
    c = cmd_now();
    if (wr_pend) begin
      mem[wr_key] = sd_dq_o;
      wr_pend = 1'b0;
    end
    if (c == C_ACT) open_row[sd_ba] = sd_a;
    if (c == C_WR) begin
      wr_key = {sd_ba, open_row[sd_ba], sd_a[8:0]};
      mem[wr_key] = sd_dq_o;
      wr_key = wr_key + 24'd1;
      wr_pend = 1'b1;
    end
    if (c == C_RD) begin
      rd_key = {sd_ba, open_row[sd_ba], sd_a[8:0]};
      rd_at = cyc + CL;
    end
    if (c == C_REF) last_ref = cyc;
    if (cyc == rd_at) sd_dq_i = mem_rd(rd_key);
    else if (cyc == rd_at + 1) sd_dq_i = mem_rd(rd_key + 24'd1);
    else sd_dq_i = 16'h0000;
  end

  // scoreboard consumer: every valid must match the oldest outstanding read
  always @(negedge clk) begin
    if (sdram_valid) begin
      n_valid++;
      if (exp_q.size() == 0) check("valid_unexpected", sdram_valid, 1'b0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data", sdram_q, e.data);
        check("rd_latency", cyc - e.ack_cyc, RD_LAT);
      end
    end
  end

  task automatic host_req(input logic [22:0] addr, input logic [31:0] data, input logic we,
                          input bit expect_valid, input bit hold, output int ack_cyc);
    bit got;
    got = 1'b0;
    sdram_addr = addr; sdram_data = data; sdram_we = we; sdram_req = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (sdram_ack) got = 1'b1;
    end
    if (!hold) sdram_req = 1'b0;
    check("ack_seen", got, 1'b1);
    ack_cyc = cyc;
    if (got && !we && expect_valid) begin
      exp_q.push_back('{data: data, ack_cyc: cyc});
      n_reads++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cke"}, sd_cke, 1'b0);
    check({tag, "_cmd"}, cmd_now(), C_DES);
    check({tag, "_ba_a"}, {sd_ba, sd_a}, 15'h0);
    check({tag, "_dqm"}, sd_dqm, 2'b11);
    check({tag, "_dq"}, {sd_dq_oe, sd_dq_o}, 17'h0);
    check({tag, "_ack_valid"}, {sdram_ack, sdram_valid}, 2'b00);
    check({tag, "_q"}, sdram_q, 32'h0);
    check({tag, "_init_done"}, init_done, 1'b0);
  endtask

  task automatic run_init(input string tag);
    logic [16:0] log_q[$];
    bit ack_seen, done;
    logic [3:0] c;
    ack_seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      c = cmd_now();
      if (sdram_ack) ack_seen = 1'b1;
      if (c != C_NOP && c != C_DES) begin
        log_q.push_back({c, sd_a});
        if (c == C_MRS) sdram_req = 1'b0;
      end
      if (init_done) done = 1'b1;
    end
    check({tag, "_done"}, init_done, 1'b1);
    check({tag, "_ncmd"}, log_q.size(), 4);
    while (log_q.size() < 4) log_q.push_back(17'h1FFFF);
    check({tag, "_pre"}, {log_q[0][16:13], log_q[0][10]}, {C_PRE, 1'b1});
    check({tag, "_ref1"}, log_q[1][16:13], C_REF);
    check({tag, "_ref2"}, log_q[2][16:13], C_REF);
    check({tag, "_mode"}, log_q[3], {C_MRS, 13'h021});
    check({tag, "_no_ack"}, ack_seen, 1'b0);
    check({tag, "_dqm"}, sd_dqm, 2'b00);
  endtask

  localparam logic [22:0] ADDR_A = {2'd0, 13'h0123, 8'h45};
  localparam logic [22:0] ADDR_B = {2'd1, 13'h0456, 8'h12};
  localparam logic [22:0] ADDR_C = {2'd2, 13'h1ABC, 8'h7F};

  initial begin
    int a0, a1, r0, r;
    reset_n = 1'b0; sdram_req = 1'b0; sdram_addr = '0; sdram_data = '0; sdram_we = 1'b0;
    repeat (4) @(negedge clk);
    check_reset("rst");
    reset_n = 1'b1;
    sdram_req = 1'b1; sdram_addr = ADDR_A; sdram_we = 1'b0;
    run_init("init");

    host_req(ADDR_A, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, a0);
    check("wr_act", {cmd_now(), sd_ba, sd_a}, {C_ACT, 2'd0, 13'h0123});
    @(negedge clk); @(negedge clk);
    check("wr_cmd", {cmd_now(), sd_a}, {C_WR, 13'h048A});
    check("wr_beat0", {sd_dq_oe, sd_dq_o}, {1'b1, 16'hBEEF});
    @(negedge clk);
    check("wr_beat1", {sd_dq_oe, sd_dq_o}, {1'b1, 16'hDEAD});
    @(negedge clk);
    check("wr_oe_off", sd_dq_oe, 1'b0);

    host_req(ADDR_A, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, a0);
    check("rd_act", {cmd_now(), sd_ba, sd_a}, {C_ACT, 2'd0, 13'h0123});
    @(negedge clk); @(negedge clk);
    check("rd_cmd", {cmd_now(), sd_a}, {C_RD, 13'h048A});
    repeat (8) @(negedge clk);

    host_req(ADDR_B, 32'h1111_2222, 1'b1, 1'b0, 1'b0, a0);
    host_req(ADDR_C, 32'h3333_4444, 1'b1, 1'b0, 1'b0, a0);
    host_req(ADDR_B, 32'h1111_2222, 1'b0, 1'b1, 1'b1, a0);
    host_req(ADDR_C, 32'h3333_4444, 1'b0, 1'b1, 1'b0, a1);
    check("b2b_gap", a1 - a0, T_RC);
    repeat (10) @(negedge clk);

    r0 = last_ref;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (last_ref != r0) break;
    end
    check("refresh_seen", last_ref != r0, 1'b1);
    r = last_ref;
    while (cyc < r + 749) @(negedge clk);
    host_req(ADDR_A, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, a0);
    check("coll_ref", last_ref, r + 750);
    check("coll_ack", a0, r + 750 + T_RC);
    repeat (10) @(negedge clk);

    host_req(ADDR_B, 32'h1111_2222, 1'b0, 1'b0, 1'b0, a0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset("mid");
    @(negedge clk);
    reset_n = 1'b1;
    run_init("reinit");

    host_req(ADDR_C, 32'h3333_4444, 1'b0, 1'b1, 1'b0, a0);
    repeat (12) @(negedge clk);
    check("exp_empty", exp_q.size(), 0);
    check("valid_count", n_valid, n_reads);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
